// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
// Operand-in and writeback-out handshake bundle of the ALU issue controller.
//   in_valid/in_ready/in_src1/in_src2/in_opcode/in_tag : op offered by dispatch
//   wb_valid/wb_ready/wb_result/wb_tag                  : tagged result to writeback
// Modports:
//   master : dispatch/writeback environment (drives ops, accepts results)
//   slave  : alu_issue_ctrl (accepts ops, drives results)
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic [OP_W-1:0]   in_opcode;
    logic [TAG_W-1:0]  in_tag;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_result;
    logic [TAG_W-1:0]  wb_tag;

    modport master (
        output in_valid, in_src1, in_src2, in_opcode, in_tag, wb_ready,
        input  in_ready, wb_valid, wb_result, wb_tag
    );

    modport slave (
        input  in_valid, in_src1, in_src2, in_opcode, in_tag, wb_ready,
        output in_ready, wb_valid, wb_result, wb_tag
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Initiator side of the ALU operand/result interface. Queues incoming ops,
// issues one per cycle into a fixed-latency ALU, follows each op through the
// ALU with a tag pipe and returns tagged results in order on a valid/ready
// writeback port.
// Ports:
//   clk, rst    : clock (posedge), asynchronous active-high reset
//   bus (slave) : in_* op handshake, wb_* result handshake
//   alu_src1/alu_src2/alu_opcode : registered operands to the ALU
//   alu_result  : ALU output, valid ALU_LAT edges after operands
//   busy        : any op held in queue, issue stage, tag pipe or result buffer
module alu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    localparam int RES_DEPTH = ALU_LAT + 2;
    localparam int QA_W      = $clog2(DEPTH);
    localparam int QC_W      = QA_W + 1;
    localparam int RA_W      = $clog2(RES_DEPTH);
    localparam int RC_W      = $clog2(RES_DEPTH + 1);
    localparam int OUT_W     = $clog2(2 * RES_DEPTH + 1);

    // ---------------- input queue ----------------
    logic [DATA_W-1:0] q_src1 [DEPTH];
    logic [DATA_W-1:0] q_src2 [DEPTH];
    logic [OP_W-1:0]   q_op   [DEPTH];
    logic [TAG_W-1:0]  q_tag  [DEPTH];
    logic [QA_W-1:0]   q_wr;
    logic [QA_W-1:0]   q_rd;
    logic [QC_W-1:0]   q_cnt;
    logic [QC_W-1:0]   q_cnt_nxt;
    logic              in_ready_r;

    // ---------------- issue stage + tag pipe ----------------
    // Bit 0 is the issue stage (op currently on alu_*), bits 1..ALU_LAT are the
    // tag-pipe stages. Bit ALU_LAT set means alu_result belongs to pt[ALU_LAT].
    logic [ALU_LAT:0]             pv;
    logic [ALU_LAT:0][TAG_W-1:0]  pt;

    // ---------------- result buffer ----------------
    logic [DATA_W-1:0] r_data [RES_DEPTH];
    logic [TAG_W-1:0]  r_tag  [RES_DEPTH];
    logic [RA_W-1:0]   r_wr;
    logic [RA_W-1:0]   r_rd;
    logic [RC_W-1:0]   r_cnt;

    logic              push;
    logic              issue;
    logic              r_push;
    logic              wb_pop;
    logic [OUT_W-1:0]  outstanding;

    function automatic logic [RA_W-1:0] r_inc(input logic [RA_W-1:0] p);
        return (p == RA_W'(RES_DEPTH - 1)) ? '0 : p + RA_W'(1);
    endfunction

    // Credit check: an op may be issued only if, after this edge's writeback
    // pop, fewer than RES_DEPTH ops are in flight or buffered. This is what
    // keeps the result buffer from ever overflowing without stalling the ALU.
    always_comb begin
        push        = bus.in_valid && in_ready_r;
        wb_pop      = (r_cnt != '0) && bus.wb_ready;
        r_push      = pv[ALU_LAT];
        outstanding = OUT_W'($countones(pv)) + OUT_W'(r_cnt);
        issue       = (q_cnt != '0) &&
                      ((outstanding - OUT_W'(wb_pop)) < OUT_W'(RES_DEPTH));
        q_cnt_nxt   = q_cnt + QC_W'(push) - QC_W'(issue);
    end

    // Queue control. in_ready comes from the registered count only, so a pop
    // on a full queue frees the slot one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr       <= '0;
            q_rd       <= '0;
            q_cnt      <= '0;
            in_ready_r <= 1'b0;
        end else begin
            q_cnt      <= q_cnt_nxt;
            in_ready_r <= (q_cnt_nxt != QC_W'(DEPTH));
            if (push)
                q_wr <= q_wr + QA_W'(1);
            if (issue)
                q_rd <= q_rd + QA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_src1[q_wr] <= bus.in_src1;
            q_src2[q_wr] <= bus.in_src2;
            q_op[q_wr]   <= bus.in_opcode;
            q_tag[q_wr]  <= bus.in_tag;
        end
    end

    // Issue stage and tag pipe. alu_* hold their last values when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_src1   <= '0;
            alu_src2   <= '0;
            alu_opcode <= '0;
            pv         <= '0;
            pt         <= '0;
        end else begin
            pv <= {pv[ALU_LAT-1:0], issue};
            pt <= {pt[ALU_LAT-1:0], q_tag[q_rd]};
            if (issue) begin
                alu_src1   <= q_src1[q_rd];
                alu_src2   <= q_src2[q_rd];
                alu_opcode <= q_op[q_rd];
            end
        end
    end

    // Result buffer control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + RC_W'(r_push) - RC_W'(wb_pop);
            if (r_push)
                r_wr <= r_inc(r_wr);
            if (wb_pop)
                r_rd <= r_inc(r_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (r_push) begin
            r_data[r_wr] <= alu_result;
            r_tag[r_wr]  <= pt[ALU_LAT];
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.wb_valid  = (r_cnt != '0);
    assign bus.wb_result = r_data[r_rd];
    assign bus.wb_tag    = r_tag[r_rd];
    assign busy          = (q_cnt != '0) || (|pv) || (r_cnt != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl: models a fixed-latency ALU, keeps an in-order
// scoreboard of expected {result, tag} built at acceptance time, and runs
// directed scenarios followed by a randomized stream.
module tb_alu_issue_ctrl;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR = 4'd4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_result;
    logic              busy;

    alu_issue_ctrl_if #(.DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W)) bus ();

    alu_issue_ctrl #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ref_alu(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // External ALU: result appears ALU_LAT edges after operands.
    logic [DATA_W-1:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= ref_alu(alu_opcode, alu_src1, alu_src2);
        for (int i = 1; i < ALU_LAT; i++)
            alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    typedef struct {
        logic [DATA_W-1:0] res;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned pop_cyc_q[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned pop_cnt  = 0;
    int unsigned last_acc_cyc = 0;

    logic              s_in_ready, s_wb_valid, s_busy, s_acc, s_pop;
    logic [DATA_W-1:0] s_wb_result;
    logic [TAG_W-1:0]  s_wb_tag;
    logic [DATA_W-1:0] last_res;
    logic [TAG_W-1:0]  last_tag;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update scoreboard, return 1ns after posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        s_in_ready  = bus.in_ready;
        s_wb_valid  = bus.wb_valid;
        s_busy      = busy;
        s_wb_result = bus.wb_result;
        s_wb_tag    = bus.wb_tag;
        s_acc       = bus.in_valid && bus.in_ready;
        s_pop       = bus.wb_valid && bus.wb_ready;
        if (exp_q.size() == 0) begin
            chk("no_spurious_wb", s_pop, 1'b0);
        end else if (s_pop) begin
            e = exp_q.pop_front();
            chk("wb_result", bus.wb_result, e.res);
            chk("wb_tag", bus.wb_tag, e.tag);
            last_res = bus.wb_result;
            last_tag = bus.wb_tag;
            pop_cnt++;
            pop_cyc_q.push_back(cyc);
        end
        if (s_acc) begin
            e.res = ref_alu(bus.in_opcode, bus.in_src1, bus.in_src2);
            e.tag = bus.in_tag;
            exp_q.push_back(e);
            last_acc_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_src1   = a;
        bus.in_src2   = b;
        bus.in_opcode = op;
        bus.in_tag    = tag;
    endtask

    task automatic set_rand_op();
        logic [OP_W-1:0] op;
        op = OP_W'($urandom_range(0, 4));
        set_op($urandom, $urandom, op, TAG_W'($urandom));
    endtask

    task automatic drain(input int unsigned max);
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        for (int unsigned n = 0; n < max; n++) begin
            cycle();
            if (!s_busy && exp_q.size() == 0)
                break;
        end
        chk("drain_idle", s_busy, 1'b0);
        chk("drain_sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int unsigned k;
        int unsigned acc;
        int unsigned p0;
        int unsigned a0;
        logic        prev_pop;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_src1 = '0; bus.in_src2 = '0;
        bus.in_opcode = '0; bus.in_tag = '0; bus.wb_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_src1", alu_src1, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();
        chk("in_ready_before_edge", s_in_ready, 1'b0);
        cycle();
        chk("in_ready_after_edge", s_in_ready, 1'b1);

        // 1. Single op latency
        set_op(3, 4, OP_ADD, 5);
        cycle();
        chk("t1_acc", s_acc, 1'b1);
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_wb_not_yet", s_wb_valid, 1'b0);
        end
        cycle();
        chk("t1_wb_valid", s_wb_valid, 1'b1);
        chk("t1_result", s_wb_result, 7);
        chk("t1_tag", s_wb_tag, 5);
        cycle();
        chk("t1_busy_clear", s_busy, 1'b0);

        // 2. Streaming 8 ADDs
        pop_cyc_q.delete();
        p0 = pop_cnt;
        a0 = 0;
        for (int i = 0; i < 8; i++) begin
            set_op(DATA_W'(i), 10, OP_ADD, TAG_W'(i));
            cycle();
            chk("t2_acc", s_acc, 1'b1);
            if (i == 0) a0 = last_acc_cyc;
        end
        drain(30);
        chk("t2_count", pop_cnt - p0, 8);
        chk("t2_first_lat", pop_cyc_q[0] - a0, ALU_LAT + 3);
        chk("t2_no_bubbles", pop_cyc_q[7] - pop_cyc_q[0], 7);

        // 3. Backpressure: 10 offered, DEPTH+RES_DEPTH accepted
        p0 = pop_cnt;
        bus.wb_ready = 1'b0;
        k = 0;
        set_rand_op();
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (s_acc) begin
                k++;
                if (k < 10) set_rand_op(); else bus.in_valid = 1'b0;
            end
        end
        chk("t3_accepted", k, DEPTH + ALU_LAT + 2);
        chk("t3_in_ready_low", s_in_ready, 1'b0);
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 40 && k < 10; i++) begin
            cycle();
            if (s_acc) begin
                k++;
                if (k < 10) set_rand_op(); else bus.in_valid = 1'b0;
            end
        end
        drain(40);
        chk("t3_all_results", pop_cnt - p0, 10);

        // 4. Full queue, wb_ready toggling
        bus.wb_ready = 1'b0;
        set_rand_op();
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (s_acc) set_rand_op();
        end
        chk("t4_full", s_in_ready, 1'b0);
        prev_pop = s_pop;
        for (int j = 0; j < 10; j++) begin
            bus.wb_ready = (j % 2 == 0);
            cycle();
            chk("t4_in_ready_follows_pop", s_in_ready, prev_pop);
            prev_pop = s_pop;
            if (s_acc) set_rand_op();
        end
        drain(40);

        // 5. Reset mid-flight
        bus.wb_ready = 1'b0;
        k = 0;
        set_rand_op();
        for (int i = 0; i < 20 && k < 5; i++) begin
            cycle();
            if (s_acc) begin
                k++;
                if (k < 5) set_rand_op(); else bus.in_valid = 1'b0;
            end
        end
        for (int i = 0; i < 5; i++) cycle();
        chk("t5_busy_before", s_busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t5_wb_valid", bus.wb_valid, 1'b0);
        chk("t5_in_ready", bus.in_ready, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_alu_src1", alu_src1, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();
        p0 = pop_cnt;
        set_op(9, 1, OP_ADD, 2);
        bus.wb_ready = 1'b1;
        cycle();
        chk("t5_acc", s_acc, 1'b1);
        drain(20);
        chk("t5_one_result", pop_cnt - p0, 1);
        chk("t5_result", last_res, 10);
        chk("t5_tag", last_tag, 2);

        // 6. Random stream of ADDs
        p0 = pop_cnt;
        acc = 0;
        for (int n = 0; n < 3000 && acc < 200; n++) begin
            set_op($urandom, $urandom, OP_ADD, TAG_W'($urandom));
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.wb_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (s_acc) acc++;
        end
        drain(50);
        chk("t6_accepted", acc, 200);
        chk("t6_results", pop_cnt - p0, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
